// File: rtl/regfile_arb_pkg.sv
// Shared types and defaults for the register-file read arbiter.
// Combinational helpers only; no latency or backpressure of its own.
package regfile_arb_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int ADDR_W_DEF  = 5;
  localparam int DATA_W_DEF  = 32;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first set request at or after rr_ptr, wrapping modulo NUM_REQ.
// Purely combinational, zero latency; no backpressure.
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_grant
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [ID_W-1:0]      off_sel;
  logic [ID_W:0]        sum;

  always_comb begin
    dbl     = {req, req} >> rr_ptr;
    rot     = dbl[NUM_REQ-1:0];
    off_sel = '0;
    // Descending scan so the smallest offset from rr_ptr wins.
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      if (rot[off]) off_sel = ID_W'(off);
    end
    any_grant = |req;
    sum = {1'b0, rr_ptr} + {1'b0, off_sel};
    if (sum >= (ID_W + 1)'(NUM_REQ)) sum = sum - (ID_W + 1)'(NUM_REQ);
    grant_idx    = sum[ID_W-1:0];
    grant_onehot = any_grant ? (NUM_REQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Round-robin share of the 32-entry register read port; grant in T, registered rsp_valid in T+1.
// Grants stall while the response slot is FULL and rsp_ready is low; consume+grant in one cycle has no bubble.
module regfile_read_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         mux_sel,
  input  logic [DATA_W-1:0]         mux_data,
  output logic                      rsp_valid,
  output logic [clog2(NUM_REQ)-1:0] rsp_id,
  output logic [ADDR_W-1:0]         rsp_addr,
  output logic [DATA_W-1:0]         rsp_data,
  input  logic                      rsp_ready
);

  localparam int ID_W = clog2(NUM_REQ);

  slot_state_e         state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [ADDR_W-1:0]   rsp_addr_q, rsp_addr_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

  logic [NUM_REQ-1:0]  pick_onehot;
  logic [ID_W-1:0]     pick_idx;
  logic                pick_any;
  logic                can_accept;
  logic                grant;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req          (req_valid),
    .rr_ptr       (rr_ptr_q),
    .grant_onehot (pick_onehot),
    .grant_idx    (pick_idx),
    .any_grant    (pick_any)
  );

  always_comb begin
    can_accept = (state_q == EMPTY) || rsp_ready;
    grant      = can_accept && pick_any;
    req_ready  = grant ? pick_onehot : '0;
    mux_sel    = grant ? req_addr[pick_idx*ADDR_W +: ADDR_W] : '0;

    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    rsp_id_d   = rsp_id_q;
    rsp_addr_d = rsp_addr_q;
    rsp_data_d = rsp_data_q;

    if (grant) begin
      state_d    = FULL;
      rsp_id_d   = pick_idx;
      rsp_addr_d = mux_sel;
      rsp_data_d = mux_data;
      rr_ptr_d   = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
    end else if (state_q == FULL && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      rr_ptr_q   <= '0;
      rsp_id_q   <= '0;
      rsp_addr_q <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      rsp_id_q   <= rsp_id_d;
      rsp_addr_q <= rsp_addr_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Bench for regfile_read_arbiter: behavioural model plus per-cycle compare and directed literal checks.
// Mux model returns 32'hA5A5_0000 | sel combinationally.
module tb_regfile_read_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [19:0] req_addr;
  logic [3:0]  req_ready;
  logic [4:0]  mux_sel;
  logic [31:0] mux_data;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [4:0]  rsp_addr;
  logic [31:0] rsp_data;
  logic        rsp_ready;

  int checks = 0;
  int errors = 0;

  regfile_read_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .mux_sel   (mux_sel),
    .mux_data  (mux_data),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_addr  (rsp_addr),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready)
  );

  assign mux_data = 32'hA5A5_0000 | {27'd0, mux_sel};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          id;
    int          addr;
    logic [31:0] data;
  } rsp_t;

  rsp_t        sb_q[$];
  bit          m_init = 1'b0;
  bit          m_full;
  int          m_ptr;
  int          m_id;
  int          m_addr;
  logic [31:0] m_data;

  function automatic int pick(input logic [3:0] v, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (((v >> ((ptr + k) % 4)) & 4'd1) != 4'd0) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  function automatic int addr_of(input logic [19:0] a, input int i);
    return int'(5'(a >> (i * 5)));
  endfunction

  always @(posedge clk) begin
    int w;
    bit can;
    if (reset) begin
      m_init = 1'b1;
      m_full = 1'b0;
      m_ptr  = 0;
      m_id   = 0;
      m_addr = 0;
      m_data = 32'd0;
      sb_q.delete();
    end else if (m_init) begin
      w   = pick(req_valid, m_ptr);
      can = !m_full || rsp_ready;
      if (can && w >= 0) begin
        m_full = 1'b1;
        m_id   = w;
        m_addr = addr_of(req_addr, w);
        m_data = 32'hA5A5_0000 + 32'(m_addr);
        m_ptr  = (w + 1) % 4;
        sb_q.push_back('{id: m_id, addr: m_addr, data: m_data});
      end else if (m_full && rsp_ready) begin
        m_full = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    int   w;
    bit   can;
    rsp_t r;
    if (m_init) begin
      w   = pick(req_valid, m_ptr);
      can = !m_full || rsp_ready;
      chk("req_ready", {28'd0, req_ready}, (can && w >= 0) ? (32'd1 << w) : 32'd0);
      chk("mux_sel", {27'd0, mux_sel}, (can && w >= 0) ? 32'(addr_of(req_addr, w)) : 32'd0);
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_full});
      chk("rsp_id", {30'd0, rsp_id}, 32'(m_id));
      chk("rsp_addr", {27'd0, rsp_addr}, 32'(m_addr));
      chk("rsp_data", rsp_data, m_data);
      if (!reset && rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          chk("consume_without_grant", 32'd1, 32'd0);
        end else begin
          r = sb_q.pop_front();
          chk("sb_id", {30'd0, rsp_id}, 32'(r.id));
          chk("sb_addr", {27'd0, rsp_addr}, 32'(r.addr));
          chk("sb_data", rsp_data, r.data);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [4:0] a);
    req_addr[i*5 +: 5] = a;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 4'b0000;
    req_addr  = 20'd0;
    rsp_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_id", {30'd0, rsp_id}, 32'd0);
    chk("reset_rsp_addr", {27'd0, rsp_addr}, 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);

    // 1: single request
    req_valid = 4'b0001;
    set_addr(0, 5'd7);
    #1;
    chk("t1_req_ready", {28'd0, req_ready}, 32'h1);
    chk("t1_mux_sel", {27'd0, mux_sel}, 32'd7);
    step();
    req_valid = 4'b0000;
    chk("t1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("t1_rsp_id", {30'd0, rsp_id}, 32'd0);
    chk("t1_rsp_addr", {27'd0, rsp_addr}, 32'd7);
    chk("t1_rsp_data", rsp_data, 32'hA5A5_0007);

    // 2: all requesters valid, pointer back at 0
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) set_addr(i, 5'(i + 1));
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t2_req_ready", {28'd0, req_ready}, 32'd1 << (k % 4));
      step();
      chk("t2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("t2_rsp_addr", {27'd0, rsp_addr}, 32'((k % 4) + 1));
    end
    req_valid = 4'b0000;
    step();

    // 3: backpressure with requesters 1 and 2 (pointer at 1)
    req_valid = 4'b0110;
    rsp_ready = 1'b0;
    #1;
    chk("t3_first_grant", {28'd0, req_ready}, 32'h2);
    step();
    req_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t3_stall_ready", {28'd0, req_ready}, 32'h0);
      chk("t3_hold_id", {30'd0, rsp_id}, 32'd1);
      chk("t3_hold_addr", {27'd0, rsp_addr}, 32'd2);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("t3_resume_grant", {28'd0, req_ready}, 32'h4);
    step();
    req_valid = 4'b0000;
    chk("t3_rsp_id", {30'd0, rsp_id}, 32'd2);
    chk("t3_rsp_addr", {27'd0, rsp_addr}, 32'd3);

    // 4: pointer at 3 wraps to 0 then 1
    req_valid = 4'b1001;
    #1;
    chk("t4_grant3", {28'd0, req_ready}, 32'h8);
    step();
    req_valid = 4'b0001;
    chk("t4_rsp_id3", {30'd0, rsp_id}, 32'd3);
    #1;
    chk("t4_grant0", {28'd0, req_ready}, 32'h1);
    step();
    chk("t4_rsp_id0", {30'd0, rsp_id}, 32'd0);
    req_valid = 4'b0011;
    #1;
    chk("t4_ptr_at_1", {28'd0, req_ready}, 32'h2);
    step();
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0000;

    // 5: reset coincides with a grant
    req_valid = 4'b0100;
    reset     = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("t5_rsp_data", rsp_data, 32'd0);
    req_valid = 4'b0101;
    #1;
    chk("t5_favour0", {28'd0, req_ready}, 32'h1);
    step();
    req_valid = 4'b0100;
    chk("t5_rsp_id", {30'd0, rsp_id}, 32'd0);

    // 6: consume and grant in the same cycle
    set_addr(2, 5'd31);
    #1;
    chk("t6_req_ready", {28'd0, req_ready}, 32'h4);
    chk("t6_mux_sel", {27'd0, mux_sel}, 32'd31);
    step();
    req_valid = 4'b0000;
    chk("t6_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("t6_rsp_id", {30'd0, rsp_id}, 32'd2);
    chk("t6_rsp_addr", {27'd0, rsp_addr}, 32'd31);
    chk("t6_rsp_data", rsp_data, 32'hA5A5_001F);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
